// File: rtl/instruction_fetcher_pkg.sv
// Shared fetch-stage definitions: state encodings, reset PC default,
// instruction width.
package instruction_fetcher_pkg;

  localparam int          INST_WIDTH   = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_VALID = 3'd2,
    S_DROP  = 3'd3,
    S_FAULT = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetcher_pc_reg.sv
// Program counter: async active-low reset, load, +4 increment, hold when
// i_en=0. Ports: i_clk, i_rst_n, i_en, i_load, i_load_pc, i_inc, o_pc, o_pc_next.
module pc_reg #(
  parameter int             LEN      = 32,
  parameter logic [LEN-1:0] RESET_PC = '0
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_en,
  input  logic           i_load,
  input  logic [LEN-1:0] i_load_pc,
  input  logic           i_inc,
  output logic [LEN-1:0] o_pc,
  output logic [LEN-1:0] o_pc_next
);

  logic [LEN-1:0] r_pc;

  // Load beats increment; the +4 wraps naturally at 2^LEN.
  always_comb begin
    o_pc_next = r_pc;
    if (i_load)
      o_pc_next = i_load_pc;
    else if (i_inc)
      o_pc_next = r_pc + LEN'(4);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_pc <= RESET_PC;
    else if (i_en)
      r_pc <= o_pc_next;
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instruction_fetcher.sv
// Fetch stage: owns the PC, single-outstanding req/ack reads, valid/ready
// to decode, redirect with wrong-path discard. Ports: clk_in, rst_in,
// rdy_in, redirect_in/_pc_in, mem_req/addr_out, mem_ack/data_in,
// if_valid/instruction/pc_out, id_ready_in, fault_out.
// Optional: FETCH_MISALIGN_CHECK_EN traps misaligned redirects into FAULT.
module instruction_fetcher
  import instruction_fetcher_pkg::*;
#(
  parameter int             LEN      = 32,
  parameter logic [LEN-1:0] RESET_PC = DEF_RESET_PC
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           rdy_in,
  input  logic           redirect_in,
  input  logic [LEN-1:0] redirect_pc_in,
  output logic           mem_req_out,
  output logic [LEN-1:0] mem_addr_out,
  input  logic           mem_ack_in,
  input  logic [LEN-1:0] mem_data_in,
  output logic           if_valid_out,
  output logic [LEN-1:0] if_instruction_out,
  output logic [LEN-1:0] if_pc_out,
  input  logic           id_ready_in,
  output logic           fault_out
);

  fetch_state_t   r_state;
  fetch_state_t   w_state_nxt;
  logic           r_pend;
  logic           w_pend_nxt;
  logic [LEN-1:0] r_addr;
  logic [LEN-1:0] r_inst;
  logic [LEN-1:0] r_ipc;
  logic [LEN-1:0] w_pc;
  logic [LEN-1:0] w_pc_next;
  logic [LEN-1:0] w_tgt;
  logic           w_mis;
  logic           w_load;
  logic           w_inc;
  logic           w_cap;

  assign w_tgt = redirect_pc_in & ~LEN'(3);

`ifdef FETCH_MISALIGN_CHECK_EN
  assign w_mis = redirect_pc_in[1:0] != 2'b00;
`else
  assign w_mis = 1'b0;
`endif

  pc_reg #(
    .LEN      (LEN),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .i_clk     (clk_in),
    .i_rst_n   (rst_in),
    .i_en      (rdy_in),
    .i_load    (w_load),
    .i_load_pc (w_tgt),
    .i_inc     (w_inc),
    .o_pc      (w_pc),
    .o_pc_next (w_pc_next)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    w_load      = 1'b0;
    w_inc       = 1'b0;
    w_cap       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (redirect_in && w_mis) begin
          w_state_nxt = S_FAULT;
        end else begin
          w_load      = redirect_in;
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        if (redirect_in && w_mis) begin
          w_state_nxt = S_FAULT;
          w_pend_nxt  = !mem_ack_in;
        end else if (redirect_in) begin
          w_load      = 1'b1;
          w_state_nxt = mem_ack_in ? S_FETCH : S_DROP;
        end else if (mem_ack_in) begin
          w_cap       = 1'b1;
          w_state_nxt = S_VALID;
        end
      end
      S_VALID: begin
        if (redirect_in && w_mis) begin
          w_state_nxt = S_FAULT;
        end else if (redirect_in) begin
          w_load      = 1'b1;
          w_state_nxt = S_FETCH;
        end else if (id_ready_in) begin
          w_inc       = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      S_DROP: begin
        // Old request still in flight at r_addr; latest target wins.
        if (redirect_in && w_mis) begin
          w_state_nxt = S_FAULT;
          w_pend_nxt  = !mem_ack_in;
        end else begin
          w_load = redirect_in;
          if (mem_ack_in)
            w_state_nxt = S_FETCH;
        end
      end
      S_FAULT: begin
        if (mem_ack_in)
          w_pend_nxt = 1'b0;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // r_addr only moves on entry to FETCH, so it holds the old address
  // through DROP and FAULT while a request is outstanding.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= S_IDLE;
      r_pend  <= 1'b0;
      r_addr  <= RESET_PC;
      r_inst  <= '0;
      r_ipc   <= '0;
    end else if (rdy_in) begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      if (w_state_nxt == S_FETCH)
        r_addr <= w_pc_next;
      if (w_cap) begin
        r_inst <= mem_data_in;
        r_ipc  <= w_pc;
      end
    end
  end

  assign mem_req_out = (r_state == S_FETCH) ||
                       (r_state == S_DROP) ||
                       ((r_state == S_FAULT) && r_pend);
  assign mem_addr_out       = r_addr;
  assign if_valid_out       = r_state == S_VALID;
  assign if_instruction_out = r_inst;
  assign if_pc_out          = r_ipc;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign fault_out = r_state == S_FAULT;
`else
  assign fault_out = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetcher.sv
// Directed, table-driven bench for instruction_fetcher.
// Rows are per-cycle inputs plus the outputs expected during that cycle.
module tb_instruction_fetcher;

  localparam logic [31:0] A0 = 32'h0000_0013;
  localparam logic [31:0] A1 = 32'h0010_0093;
  localparam logic [31:0] A2 = 32'h0020_0113;
  localparam logic [31:0] A3 = 32'h0030_0193;
  localparam logic [31:0] A4 = 32'h0040_0213;
  localparam logic [31:0] A5 = 32'h0050_0293;
  localparam logic [31:0] A6 = 32'h0060_0313;
  localparam logic [31:0] DB = 32'hDEAD_BEEF;
  localparam int          NV = 30;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        redirect_in;
  logic [31:0] redirect_pc_in;
  logic        mem_req_out;
  logic [31:0] mem_addr_out;
  logic        mem_ack_in;
  logic [31:0] mem_data_in;
  logic        if_valid_out;
  logic [31:0] if_instruction_out;
  logic [31:0] if_pc_out;
  logic        id_ready_in;
  logic        fault_out;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        rdy;
    logic        rd;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] dat;
    logic        idr;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        flt;
  } vec_t;

  vec_t vt [NV];

  always #5 clk_in = ~clk_in;

  instruction_fetcher dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .rdy_in             (rdy_in),
    .redirect_in        (redirect_in),
    .redirect_pc_in     (redirect_pc_in),
    .mem_req_out        (mem_req_out),
    .mem_addr_out       (mem_addr_out),
    .mem_ack_in         (mem_ack_in),
    .mem_data_in        (mem_data_in),
    .if_valid_out       (if_valid_out),
    .if_instruction_out (if_instruction_out),
    .if_pc_out          (if_pc_out),
    .id_ready_in        (id_ready_in),
    .fault_out          (fault_out)
  );

  task automatic row(
    input int i,
    input logic rdy, input logic rd, input logic [31:0] rpc,
    input logic ack, input logic [31:0] dat, input logic idr,
    input logic req, input logic [31:0] addr, input logic vld,
    input logic [31:0] inst, input logic [31:0] pc, input logic flt);
    vt[i] = '{rdy, rd, rpc, ack, dat, idr, req, addr, vld, inst, pc, flt};
  endtask

  task automatic chk_out(
    input string name, input logic req, input logic [31:0] addr,
    input logic vld, input logic [31:0] inst, input logic [31:0] pc,
    input logic flt);
    n_cmp++;
    if ({mem_req_out, mem_addr_out, if_valid_out, if_instruction_out,
         if_pc_out, fault_out} !== {req, addr, vld, inst, pc, flt}) begin
      n_bad++;
      $display("FAIL %s: got req=%b addr=%h vld=%b inst=%h pc=%h flt=%b want req=%b addr=%h vld=%b inst=%h pc=%h flt=%b",
               name, mem_req_out, mem_addr_out, if_valid_out,
               if_instruction_out, if_pc_out, fault_out,
               req, addr, vld, inst, pc, flt);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", name, got, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic rd,
                       input logic [31:0] rpc, input logic ack,
                       input logic [31:0] dat, input logic idr);
    rdy_in         = rdy;
    redirect_in    = rd;
    redirect_pc_in = rpc;
    mem_ack_in     = ack;
    mem_data_in    = dat;
    id_ready_in    = idr;
  endtask

  initial begin
    bit found;
    // zero-wait fetches at 0x0, 0x4, 0x8, one per 2 cycles
    row( 0, 1, 0, 0, 0, 0,  1, 0, 32'h0,  0, 0,  0,  0);
    row( 1, 1, 0, 0, 1, A0, 1, 1, 32'h0,  0, 0,  0,  0);
    row( 2, 1, 0, 0, 0, 0,  1, 0, 32'h0,  1, A0, 0,  0);
    row( 3, 1, 0, 0, 1, A1, 1, 1, 32'h4,  0, A0, 0,  0);
    row( 4, 1, 0, 0, 0, 0,  1, 0, 32'h4,  1, A1, 4,  0);
    row( 5, 1, 0, 0, 1, A2, 1, 1, 32'h8,  0, A1, 4,  0);
    // decode stalls 4 cycles, then 3-cycle-late ack
    row( 6, 1, 0, 0, 0, 0,  0, 0, 32'h8,  1, A2, 8,  0);
    row( 7, 1, 0, 0, 0, 0,  0, 0, 32'h8,  1, A2, 8,  0);
    row( 8, 1, 0, 0, 0, 0,  0, 0, 32'h8,  1, A2, 8,  0);
    row( 9, 1, 0, 0, 0, 0,  0, 0, 32'h8,  1, A2, 8,  0);
    row(10, 1, 0, 0, 0, 0,  1, 0, 32'h8,  1, A2, 8,  0);
    row(11, 1, 0, 0, 0, 0,  0, 1, 32'hC,  0, A2, 8,  0);
    row(12, 1, 0, 0, 0, 0,  0, 1, 32'hC,  0, A2, 8,  0);
    row(13, 1, 0, 0, 0, 0,  0, 1, 32'hC,  0, A2, 8,  0);
    row(14, 1, 0, 0, 1, A3, 0, 1, 32'hC,  0, A2, 8,  0);
    row(15, 1, 0, 0, 0, 0,  1, 0, 32'hC,  1, A3, 12, 0);
    // redirect 0x100 in FETCH without ack; old ack carries DEADBEEF
    row(16, 1, 1, 32'h100, 0, 0, 0, 1, 32'h10, 0, A3, 12, 0);
    row(17, 1, 0, 0, 0, 0,  0, 1, 32'h10, 0, A3, 12, 0);
    row(18, 1, 0, 0, 1, DB, 0, 1, 32'h10, 0, A3, 12, 0);
    row(19, 1, 0, 0, 1, A4, 0, 1, 32'h100, 0, A3, 12, 0);
    // redirect 0x40 in the same cycle as accept
    row(20, 1, 1, 32'h40, 0, 0, 1, 0, 32'h100, 1, A4, 32'h100, 0);
    row(21, 1, 0, 0, 1, A5, 0, 1, 32'h40, 0, A4, 32'h100, 0);
    // rdy_in=0 ignores redirect and accept
    row(22, 0, 1, 32'h200, 0, 0, 1, 0, 32'h40, 1, A5, 32'h40, 0);
    row(23, 1, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 32'h40, 1, A5, 32'h40, 0);
    row(24, 1, 0, 0, 1, A6, 0, 1, 32'hFFFF_FFFC, 0, A5, 32'h40, 0);
    // accept at top of memory wraps to 0
    row(25, 1, 0, 0, 0, 0,  1, 0, 32'hFFFF_FFFC, 1, A6, 32'hFFFF_FFFC, 0);
    // redirect with ack same cycle: data discarded
    row(26, 1, 1, 32'h80, 1, 32'hBAD0_BAD0, 0,
        1, 32'h0, 0, A6, 32'hFFFF_FFFC, 0);
    // misaligned redirect 0x102 while request at 0x80 is outstanding
    row(27, 1, 1, 32'h102, 0, 0, 0, 1, 32'h80, 0, A6, 32'hFFFF_FFFC, 0);
`ifdef FETCH_MISALIGN_CHECK_EN
    row(28, 1, 0, 0, 1, 32'h1111_1111, 0,
        1, 32'h80, 0, A6, 32'hFFFF_FFFC, 1);
    row(29, 1, 0, 0, 0, 0, 0, 0, 32'h80, 0, A6, 32'hFFFF_FFFC, 1);
`else
    row(28, 1, 0, 0, 1, 32'h1111_1111, 0,
        1, 32'h80, 0, A6, 32'hFFFF_FFFC, 0);
    row(29, 1, 0, 0, 0, 0, 0, 1, 32'h100, 0, A6, 32'hFFFF_FFFC, 0);
`endif

    rst_in = 1'b0;
    drive(1, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk_in);
    chk_out("reset", 0, 32'h0, 0, 0, 0, 0);
    rst_in = 1'b1;

    for (int i = 0; i < NV; i++) begin
      chk_out($sformatf("row%0d", i), vt[i].req, vt[i].addr, vt[i].vld,
              vt[i].inst, vt[i].pc, vt[i].flt);
      drive(vt[i].rdy, vt[i].rd, vt[i].rpc, vt[i].ack, vt[i].dat,
            vt[i].idr);
      @(negedge clk_in);
    end
    drive(1, 0, 0, 0, 0, 0);

`ifdef FETCH_MISALIGN_CHECK_EN
    // FAULT is sticky: no requests even with aligned redirects
    for (int k = 0; k < 5; k++) begin
      chk1($sformatf("fault_noreq%0d", k), mem_req_out, 1'b0);
      chk1($sformatf("fault_hold%0d", k), fault_out, 1'b1);
      drive(1, k[0], 32'h100, 0, 0, 1);
      @(negedge clk_in);
    end
    drive(1, 0, 0, 0, 0, 0);
`else
    // DROP: two redirects before the old ack, latest wins
    chk_out("drop_a", 1, 32'h100, 0, A6, 32'hFFFF_FFFC, 0);
    drive(1, 1, 32'h200, 0, 0, 0);
    @(negedge clk_in);
    chk_out("drop_b", 1, 32'h100, 0, A6, 32'hFFFF_FFFC, 0);
    drive(1, 1, 32'h300, 0, 0, 0);
    @(negedge clk_in);
    chk_out("drop_c", 1, 32'h100, 0, A6, 32'hFFFF_FFFC, 0);
    drive(1, 0, 0, 1, 32'hCAFE_0000, 0);
    @(negedge clk_in);
    drive(1, 0, 0, 0, 0, 0);
    found = 1'b0;
    for (int k = 0; k < 4 && !found; k++) begin
      if (mem_req_out && mem_addr_out == 32'h300)
        found = 1'b1;
      else
        @(negedge clk_in);
    end
    chk1("req_at_0x300", found, 1'b1);
    drive(1, 0, 0, 1, 32'h1234_5678, 0);
    @(negedge clk_in);
    drive(1, 0, 0, 0, 0, 0);
    chk_out("valid_0x300", 0, 32'h300, 1, 32'h1234_5678, 32'h300, 0);
`endif

    // async reset between clock edges
    #2 rst_in = 1'b0;
    #1 chk_out("async_reset", 0, 32'h0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetcher.md
# instruction_fetcher

Instruction-fetch stage of the ToyCPU pipeline, sitting directly upstream of the instruction decoder. Owns the program counter, issues single-outstanding word reads to instruction memory over a req/ack handshake, and presents each fetched instruction and its PC to decode through a valid/ready interface. Accepts PC redirects from the branch/jump resolution stage and discards wrong-path fetches in flight.

## Interface
- `LEN`, 32, data/address width in bits
- `RESET_PC`, 32'h0000_0000, PC loaded on reset
- `clk_in`  input  1  clock; all state updates on rising edge
- `rst_in`  input  1  reset, asynchronous assert, active-low
- `rdy_in`  input  1  global enable; 0 freezes all state
- `redirect_in`  input  1  PC redirect request (taken branch/jump)
- `redirect_pc_in`  input  LEN  redirect target
- `mem_req_out`  output  1  instruction read request
- `mem_addr_out`  output  LEN  read address; stable while `mem_req_out`=1
- `mem_ack_in`  input  1  read complete; `mem_data_in` valid this cycle
- `mem_data_in`  input  LEN  instruction word
- `if_valid_out`  output  1  instruction to decode is valid
- `if_instruction_out`  output  LEN  instruction to decode
- `if_pc_out`  output  LEN  PC of `if_instruction_out`
- `id_ready_in`  input  1  decode accepts instruction this cycle
- `fault_out`  output  1  misaligned-redirect fault (see Configuration)

## Operation
- States: IDLE, FETCH, VALID, DROP, FAULT.
- Reset (async, `rst_in`=0): state IDLE, pc=`RESET_PC`; outputs `mem_req_out`=0, `mem_addr_out`=`RESET_PC`, `if_valid_out`=0, `if_instruction_out`=0, `if_pc_out`=0, `fault_out`=0.
- IDLE -> FETCH unconditionally on first enabled edge.
- FETCH: `mem_req_out`=1, `mem_addr_out`=pc. On `mem_ack_in`: latch data and pc into output regs, -> VALID.
- VALID: `if_valid_out`=1. On `id_ready_in`: pc <= pc+4 (mod 2^LEN, wraps 0xFFFF_FFFC -> 0), -> FETCH.
- Redirect (priority over all other events in every state except FAULT):
  - VALID: drop instruction (`if_valid_out`->0 even if `id_ready_in`=1 same cycle), pc <= target, -> FETCH.
  - FETCH, no ack: request must stay held with same address; pc <= target, -> DROP.
  - FETCH with ack same cycle: discard data, pc <= target, -> FETCH.
  - DROP, no ack: pc <= target (latest wins), stay DROP.
  - DROP with ack: discard data, pc <= target, -> FETCH.
- DROP: `mem_req_out`=1 at the old address until ack; data discarded; -> FETCH at pc.
- `rdy_in`=0: no state/register change; `mem_ack_in`, `redirect_in`, `id_ready_in` ignored. Memory side must not ack while `rdy_in`=0.
- Single outstanding request; never issues a new address before the previous ack.

## Timing
- Ack in the request's first cycle is legal (combinational memory).
- Reset release to first `mem_req_out`: 1 edge.
- Ack to `if_valid_out`: 1 cycle (registered).
- Accept to next `mem_req_out`: 1 cycle. Zero-wait memory throughput: 1 instruction per 2 cycles.
- Redirect to request at target: next cycle from VALID/FETCH-with-ack; from DROP, the cycle after old ack.
- All outputs registered or decoded from state; no combinational input-to-output path.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined: redirect with `redirect_pc_in[1:0]`!=0 -> FAULT (in any state, discarding anything in flight once its ack arrives); `fault_out`=1, `if_valid_out`=0, no further requests until reset. An outstanding request stays asserted until acked.
- Undefined: target low two bits forced to 00; FAULT unreachable; `fault_out` tied 0.

## Structure
- Shared defines file: fetch-state encodings, `RESET_PC` default, `INST_WIDTH`.
- Sub-module `pc_reg`: PC register with async active-low reset, load (redirect), increment (+4), hold on `rdy_in`=0.

## Test plan
- Reset, zero-wait memory, `id_ready_in`=1: requests at 0x0, 0x4, 0x8; `if_pc_out` sequence 0x0, 0x4, 0x8, one instruction per 2 cycles.
- Memory ack delayed 3 cycles, `id_ready_in`=0 for 4 cycles in VALID: `mem_addr_out` stable while requesting, `if_instruction_out` held, no new request until accept.
- Redirect to 0x100 during FETCH without ack, ack 2 cycles later with 0xDEADBEEF: data discarded, next request 0x100, `if_valid_out` never shows 0xDEADBEEF.
- Redirect to 0x40 same cycle as VALID accept: instruction dropped, next request 0x40, not pc+4.
- PC 0xFFFF_FFFC accepted: next request address 0x0.
- `FETCH_MISALIGN_CHECK_EN`: redirect to 0x102 -> `fault_out`=1, no request thereafter; without macro -> request at 0x100.
